demux12_rr_ctrl: RTL and testbench

DEMUX12_RR_CTRL -- requirements
Module: demux12_rr_ctrl

---
 rtl/demux12_rr_ctrl.sv | 149 ++++++++++++++
 tb/tb_demux12_rr_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux12_rr_ctrl.sv
// demux12_rr_ctrl: routes a 4-bit ready/valid input stream to one of two
// registered output channels (A/B), either alternating round-robin or by an
// explicit select. Each channel keeps a wrapping count of delivered words.
// A run/drain FSM gates acceptance so that held words can flush before idling.
module demux12_rr_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             x_sel,
  input  logic [3:0]       X,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [3:0]       A,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [3:0]       B,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             rr_ptr_r;
  logic [3:0]       a_data_r;
  logic             a_valid_r;
  logic [3:0]       b_data_r;
  logic             b_valid_r;
  logic [CNT_W-1:0] cnt_a_r;
  logic [CNT_W-1:0] cnt_b_r;

  logic target_s;
  logic a_take_s;
  logic b_take_s;
  logic target_free_s;
  logic x_ready_s;
  logic accept_s;
  logic load_a_s;
  logic load_b_s;
  logic a_valid_nxt_s;
  logic b_valid_nxt_s;

  // Handshake decode: pick the target channel, decide acceptance and the
  // post-edge occupancy of each output register.
  always_comb begin
    target_s      = 1'b0;
    target_free_s = 1'b0;
    x_ready_s     = 1'b0;
    a_take_s      = a_valid_r & a_ready;
    b_take_s      = b_valid_r & b_ready;

    if (mode) begin
      target_s = x_sel;
    end else begin
      target_s = rr_ptr_r;
    end

    // A register being drained this same cycle counts as free, which is
    // what lets one channel sustain a word every cycle.
    if (target_s) begin
      target_free_s = ~b_valid_r | b_take_s;
    end else begin
      target_free_s = ~a_valid_r | a_take_s;
    end

    if (state_r == RUN) begin
      x_ready_s = target_free_s;
    end else begin
      x_ready_s = 1'b0;
    end

    accept_s      = x_valid & x_ready_s;
    load_a_s      = accept_s & ~target_s;
    load_b_s      = accept_s & target_s;
    a_valid_nxt_s = load_a_s | (a_valid_r & ~a_take_s);
    b_valid_nxt_s = load_b_s | (b_valid_r & ~b_take_s);
  end

  // Control FSM, round-robin pointer, output registers and delivery counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rr_ptr_r  <= 1'b0;
      a_data_r  <= 4'b0000;
      a_valid_r <= 1'b0;
      b_data_r  <= 4'b0000;
      b_valid_r <= 1'b0;
      cnt_a_r   <= {CNT_W{1'b0}};
      cnt_b_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE:    if (en) state_r <= RUN;
        RUN:     if (!en) state_r <= DRAIN;
        DRAIN:   if (!a_valid_nxt_s && !b_valid_nxt_s) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase

      if (accept_s && !mode) begin
        rr_ptr_r <= ~rr_ptr_r;
      end

      // Data is zeroed whenever valid drops so the outputs read 0 while empty.
      if (load_a_s) begin
        a_data_r  <= X;
        a_valid_r <= 1'b1;
      end else if (a_take_s) begin
        a_data_r  <= 4'b0000;
        a_valid_r <= 1'b0;
      end

      if (load_b_s) begin
        b_data_r  <= X;
        b_valid_r <= 1'b1;
      end else if (b_take_s) begin
        b_data_r  <= 4'b0000;
        b_valid_r <= 1'b0;
      end

      if (a_take_s) begin
        cnt_a_r <= cnt_a_r + CNT_ONE;
      end
      if (b_take_s) begin
        cnt_b_r <= cnt_b_r + CNT_ONE;
      end
    end
  end

  assign x_ready = x_ready_s;
  assign A       = a_data_r;
  assign a_valid = a_valid_r;
  assign B       = b_data_r;
  assign b_valid = b_valid_r;
  assign cnt_a   = cnt_a_r;
  assign cnt_b   = cnt_b_r;
  assign busy    = (state_r != IDLE);

endmodule

// File: tb/tb_demux12_rr_ctrl.sv
// Directed bench for demux12_rr_ctrl: round-robin, backpressure, drain,
// counter wrap, mode switch and asynchronous reset with hand-computed values.
module tb_demux12_rr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       x_sel;
  logic [3:0] X;
  logic       x_valid;
  logic       x_ready;
  logic [3:0] A;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] B;
  logic       b_valid;
  logic       b_ready;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  logic       busy;

  int tests_run;
  int tests_failed;

  demux12_rr_ctrl #(.CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .x_sel   (x_sel),
    .X       (X),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .A       (A),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .B       (B),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .busy    (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulse reset between edges and confirm every output clears before the next edge.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_a_valid"}, 32'(a_valid), 32'd0);
    check_eq({tag, "_b_valid"}, 32'(b_valid), 32'd0);
    check_eq({tag, "_A"},       32'(A),       32'd0);
    check_eq({tag, "_B"},       32'(B),       32'd0);
    check_eq({tag, "_cnt_a"},   32'(cnt_a),   32'd0);
    check_eq({tag, "_cnt_b"},   32'(cnt_b),   32'd0);
    check_eq({tag, "_x_ready"}, 32'(x_ready), 32'd0);
    check_eq({tag, "_busy"},    32'(busy),    32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    x_sel   = 1'b0;
    X       = 4'd0;
    x_valid = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;

    // Reset state
    tick();
    pulse_reset("rst");

    // Round-robin: 1,3 on A and 2,4 on B
    en = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    #1;
    check_eq("idle_x_ready", 32'(x_ready), 32'd0);
    tick();
    check_eq("run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      X = 4'(i + 1); x_valid = 1'b1;
      #1;
      check_eq("rr_x_ready", 32'(x_ready), 32'd1);
      tick();
      if (i % 2 == 0) begin
        check_eq("rr_a_valid", 32'(a_valid), 32'd1);
        check_eq("rr_A",       32'(A),       32'(i + 1));
      end else begin
        check_eq("rr_b_valid", 32'(b_valid), 32'd1);
        check_eq("rr_B",       32'(B),       32'(i + 1));
      end
    end
    x_valid = 1'b0;
    tick();
    check_eq("rr_cnt_a",   32'(cnt_a),   32'd2);
    check_eq("rr_cnt_b",   32'(cnt_b),   32'd2);
    check_eq("rr_a_empty", 32'(a_valid), 32'd0);
    check_eq("rr_B_zero",  32'(B),       32'd0);

    // Backpressure on A
    mode = 1'b1; x_sel = 1'b0; a_ready = 1'b0;
    X = 4'd5; x_valid = 1'b1;
    tick();
    check_eq("bp_A5", 32'(A), 32'd5);
    X = 4'd6;
    #1;
    check_eq("bp_x_ready_low", 32'(x_ready), 32'd0);
    tick();
    check_eq("bp_A_held",     32'(A),       32'd5);
    check_eq("bp_valid_held", 32'(a_valid), 32'd1);
    a_ready = 1'b1;
    #1;
    check_eq("bp_x_ready_high", 32'(x_ready), 32'd1);
    tick();
    check_eq("bp_A6",     32'(A),     32'd6);
    check_eq("bp_cnt_a3", 32'(cnt_a), 32'd3);
    x_valid = 1'b0;
    tick();
    check_eq("bp_cnt_a4", 32'(cnt_a), 32'd4);
    check_eq("bp_A_zero", 32'(A),     32'd0);

    // Drain with a held word on A
    a_ready = 1'b0; X = 4'd9; x_valid = 1'b1;
    tick();
    check_eq("dr_A9", 32'(A), 32'd9);
    en = 1'b0; X = 4'd7;
    tick();
    #1;
    check_eq("dr_busy",    32'(busy),    32'd1);
    check_eq("dr_x_ready", 32'(x_ready), 32'd0);
    tick();
    check_eq("dr_A_still", 32'(A), 32'd9);
    x_valid = 1'b0; a_ready = 1'b1;
    tick();
    check_eq("dr_idle_busy", 32'(busy),    32'd0);
    check_eq("dr_a_valid",   32'(a_valid), 32'd0);
    check_eq("dr_cnt_a5",    32'(cnt_a),   32'd5);

    // Counter wrap: 17 words on B
    pulse_reset("rst2");
    en = 1'b1; mode = 1'b1; x_sel = 1'b1; b_ready = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      X = 4'(k); x_valid = 1'b1;
      tick();
    end
    check_eq("wrap_cnt_b0", 32'(cnt_b), 32'd0);
    check_eq("wrap_B17",    32'(B),     32'd1);
    x_valid = 1'b0;
    tick();
    check_eq("wrap_cnt_b1", 32'(cnt_b), 32'd1);
    check_eq("wrap_cnt_a0", 32'(cnt_a), 32'd0);

    // Mode switch with rr_ptr parked at B
    mode = 1'b0; X = 4'd3; x_valid = 1'b1;
    tick();
    check_eq("ms_A3", 32'(A), 32'd3);
    mode = 1'b1; x_sel = 1'b0; X = 4'd10;
    tick();
    check_eq("ms_A10", 32'(A), 32'd10);
    X = 4'd11;
    tick();
    check_eq("ms_A11",       32'(A),       32'd11);
    check_eq("ms_b_empty",   32'(b_valid), 32'd0);
    mode = 1'b0; X = 4'd12;
    tick();
    check_eq("ms_B12",    32'(B),       32'd12);
    check_eq("ms_a_done", 32'(a_valid), 32'd0);
    x_valid = 1'b0;
    tick();
    check_eq("ms_cnt_a", 32'(cnt_a), 32'd3);
    check_eq("ms_cnt_b", 32'(cnt_b), 32'd2);

    // Asynchronous reset with both registers loaded
    mode = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
    x_sel = 1'b0; X = 4'd1; x_valid = 1'b1;
    tick();
    x_sel = 1'b1; X = 4'd2;
    tick();
    x_valid = 1'b0;
    check_eq("ar_a_loaded", 32'(a_valid), 32'd1);
    check_eq("ar_b_loaded", 32'(b_valid), 32'd1);
    pulse_reset("ar");
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    check_eq("ar_leave_idle", 32'(busy),  32'd1);
    check_eq("ar_no_deliv_a", 32'(cnt_a), 32'd0);
    check_eq("ar_no_deliv_b", 32'(cnt_b), 32'd0);
    en = 1'b0;
    tick();
    tick();
    check_eq("ar_back_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
